// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream (length, payload, checksum) and
// writes it into the 32x8 instruction memory, zero-filling the tail and holding the CPU in reset until a good load.
module prog_loader (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic       mem_wen_o,
  output logic [4:0] mem_addr_o,
  output logic [7:0] mem_data_o,
  output logic       cpu_rst_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] err_o
);

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = 6;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_FILL, S_DONE, S_ERR
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   len, len_n;
  logic [DW-1:0]   sum, sum_n;
  logic            wen_n;
  logic [AW-1:0]   addr_n;
  logic [DW-1:0]   data_n;
  logic            cpu_rst_n;
  logic            done_n;
  logic [1:0]      err_n;
  logic            accept;

  assign byte_ready_o = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign busy_o       = byte_ready_o || (state == S_FILL);
  assign accept       = byte_valid_i && byte_ready_o;

  // State, counters and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len        <= '0;
      sum        <= '0;
      mem_wen_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      cpu_rst_o  <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= ERR_NONE;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      len        <= len_n;
      sum        <= sum_n;
      mem_wen_o  <= wen_n;
      mem_addr_o <= addr_n;
      mem_data_o <= data_n;
      cpu_rst_o  <= cpu_rst_n;
      done_o     <= done_n;
      err_o      <= err_n;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    len_n     = len;
    sum_n     = sum;
    wen_n     = 1'b0;
    addr_n    = mem_addr_o;
    data_n    = mem_data_o;
    cpu_rst_n = cpu_rst_o;
    done_n    = done_o;
    err_n     = err_o;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_n = S_LEN;
          cnt_n   = '0;
          sum_n   = '0;
          err_n   = ERR_NONE;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (byte_i == 8'd0 || byte_i > 8'(DEPTH)) begin
            state_n = S_ERR;
            err_n   = ERR_LEN;
          end else begin
            state_n = S_DATA;
            len_n   = CW'(byte_i);
            cnt_n   = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          wen_n  = 1'b1;
          addr_n = AW'(cnt);
          data_n = byte_i;
          sum_n  = sum + byte_i;
          cnt_n  = cnt + CW'(1);
          if (cnt + CW'(1) == len) state_n = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (byte_i != sum) begin
            state_n = S_ERR;
            err_n   = ERR_CSUM;
          end else if (len == CW'(DEPTH)) begin
            state_n   = S_DONE;
            done_n    = 1'b1;
            cpu_rst_n = 1'b0;
          end else begin
            // First fill word (address N) goes out on the checksum edge
            state_n = S_FILL;
            wen_n   = 1'b1;
            addr_n  = AW'(len);
            data_n  = '0;
            cnt_n   = len + CW'(1);
          end
        end
      end
      S_FILL: begin
        if (cnt == CW'(DEPTH)) begin
          state_n   = S_DONE;
          done_n    = 1'b1;
          cpu_rst_n = 1'b0;
        end else begin
          wen_n  = 1'b1;
          addr_n = AW'(cnt);
          data_n = '0;
          cnt_n  = cnt + CW'(1);
        end
      end
      S_DONE, S_ERR: begin
        if (start_i) begin
          state_n   = S_LEN;
          cnt_n     = '0;
          sum_n     = '0;
          err_n     = ERR_NONE;
          done_n    = 1'b0;
          cpu_rst_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as frames
// are driven and popped by a write monitor on the falling clock edge.
module tb_prog_loader;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic       byte_valid_i = 1'b0;
  logic       byte_ready_o;
  logic       mem_wen_o;
  logic [4:0] mem_addr_o;
  logic [7:0] mem_data_o;
  logic       cpu_rst_o;
  logic       busy_o;
  logic       done_o;
  logic [1:0] err_o;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  prog_loader dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Hold byte_valid_i until the handshake completes; returns 1ns after the accepting edge
  task automatic send_byte(input logic [7:0] b, input string tag);
    logic rdy;
    bit   acc;
    acc = 1'b0;
    byte_i = b;
    byte_valid_i = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk_i);
      rdy = byte_ready_o;
      @(posedge clk_i);
      #1;
      acc = rdy;
    end
    byte_valid_i = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s_accept got no handshake want accept within 20 cycles", tag);
    end
  endtask

  task automatic monitor();
    logic [12:0] e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && mem_wen_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected got addr=%0d data=%02h want no write", mem_addr_o, mem_data_o);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr_o, mem_data_o} !== e) begin
            errors++;
            $display("FAIL write_seq got addr=%0d data=%02h want addr=%0d data=%02h",
                     mem_addr_o, mem_data_o, e[12:8], e[7:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if ({cpu_rst_o, mem_wen_o, busy_o, done_o, byte_ready_o, mem_addr_o, mem_data_o, err_o} !==
        {1'b1, 4'b0000, 5'd0, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_async got rst=%b wen=%b busy=%b done=%b rdy=%b a=%0d d=%02h err=%b want 1 0 0 0 0 0 00 00",
               cpu_rst_o, mem_wen_o, busy_o, done_o, byte_ready_o, mem_addr_o, mem_data_o, err_o);
    end
    tick();
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({cpu_rst_o, mem_wen_o, busy_o, done_o, byte_ready_o, mem_addr_o, mem_data_o, err_o} !==
          {1'b1, 4'b0000, 5'd0, 8'h00, 2'b00}) begin
        errors++;
        $display("FAIL reset_idle_%0d got rst=%b wen=%b busy=%b done=%b rdy=%b err=%b want 1 0 0 0 0 00",
                 i, cpu_rst_o, mem_wen_o, busy_o, done_o, byte_ready_o, err_o);
      end
    end
  endtask

  // Short frame: 3 data bytes, 29 fill words, done 29 edges after the checksum
  task automatic test_basic();
    logic [7:0] d[3];
    d = '{8'h21, 8'h42, 8'hE0};
    pulse_start();
    checks++;
    if ({busy_o, byte_ready_o} !== 2'b11) begin
      errors++;
      $display("FAIL basic_len_state got busy=%b rdy=%b want 1 1", busy_o, byte_ready_o);
    end
    for (int k = 0; k < 3; k++) push_wr(5'(k), d[k]);
    for (int a = 3; a < 32; a++) push_wr(5'(a), 8'h00);
    send_byte(8'h03, "basic_len");
    for (int k = 0; k < 3; k++) send_byte(d[k], "basic_data");
    send_byte(8'h43, "basic_csum");
    repeat (28) tick();
    checks++;
    if ({done_o, cpu_rst_o, busy_o} !== 3'b011) begin
      errors++;
      $display("FAIL basic_pre_done got done=%b cpu_rst=%b busy=%b want 0 1 1", done_o, cpu_rst_o, busy_o);
    end
    tick();
    checks++;
    if ({done_o, cpu_rst_o, busy_o, err_o} !== 5'b10000) begin
      errors++;
      $display("FAIL basic_done got done=%b cpu_rst=%b busy=%b err=%b want 1 0 0 00", done_o, cpu_rst_o, busy_o, err_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_writes_left got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_bad_len();
    pulse_start();
    checks++;
    if ({done_o, cpu_rst_o, err_o} !== 4'b0100) begin
      errors++;
      $display("FAIL badlen_restart got done=%b cpu_rst=%b err=%b want 0 1 00", done_o, cpu_rst_o, err_o);
    end
    send_byte(8'h00, "badlen_zero");
    checks++;
    if ({err_o, byte_ready_o, busy_o, cpu_rst_o, done_o} !== 6'b010010) begin
      errors++;
      $display("FAIL badlen_zero got err=%b rdy=%b busy=%b cpu_rst=%b done=%b want 01 0 0 1 0",
               err_o, byte_ready_o, busy_o, cpu_rst_o, done_o);
    end
    repeat (3) tick();
    pulse_start();
    checks++;
    if (err_o !== 2'b00) begin
      errors++;
      $display("FAIL badlen_clear got err=%b want 00", err_o);
    end
    send_byte(8'h21, "badlen_33");
    checks++;
    if ({err_o, byte_ready_o, cpu_rst_o} !== 4'b0101) begin
      errors++;
      $display("FAIL badlen_33 got err=%b rdy=%b cpu_rst=%b want 01 0 1", err_o, byte_ready_o, cpu_rst_o);
    end
    repeat (3) tick();
  endtask

  task automatic test_bad_csum();
    pulse_start();
    push_wr(5'd0, 8'h10);
    push_wr(5'd1, 8'h20);
    send_byte(8'h02, "badcsum_len");
    send_byte(8'h10, "badcsum_d0");
    send_byte(8'h20, "badcsum_d1");
    send_byte(8'h31, "badcsum_csum");
    checks++;
    if ({err_o, done_o, cpu_rst_o, mem_wen_o} !== 5'b10010) begin
      errors++;
      $display("FAIL badcsum_err got err=%b done=%b cpu_rst=%b wen=%b want 10 0 1 0", err_o, done_o, cpu_rst_o, mem_wen_o);
    end
    repeat (35) tick();
    checks++;
    if (exp_q.size() != 0 || err_o !== 2'b10) begin
      errors++;
      $display("FAIL badcsum_hold got pending=%0d err=%b want 0 10", exp_q.size(), err_o);
    end
  endtask

  // Full 32-byte frame with random valid gaps and a stray start_i during DATA
  task automatic test_full_gaps();
    logic [7:0] s;
    s = 8'h00;
    pulse_start();
    for (int k = 0; k < 32; k++) push_wr(5'(k), 8'(k));
    send_byte(8'h20, "full_len");
    for (int k = 0; k < 32; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (k == 5) start_i = 1'b1;
      send_byte(8'(k), "full_data");
      start_i = 1'b0;
      s = s + 8'(k);
    end
    checks++;
    if ({busy_o, byte_ready_o, done_o} !== 3'b110) begin
      errors++;
      $display("FAIL full_csum_wait got busy=%b rdy=%b done=%b want 1 1 0", busy_o, byte_ready_o, done_o);
    end
    repeat (2) tick();
    send_byte(s, "full_csum");
    checks++;
    if ({done_o, cpu_rst_o, busy_o, err_o, mem_wen_o} !== 6'b100000) begin
      errors++;
      $display("FAIL full_done got done=%b cpu_rst=%b busy=%b err=%b wen=%b want 1 0 0 00 0",
               done_o, cpu_rst_o, busy_o, err_o, mem_wen_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_writes_left got %0d pending want 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    pulse_start();
    push_wr(5'd0, 8'hAA);
    push_wr(5'd1, 8'hBB);
    send_byte(8'h05, "arst_len");
    send_byte(8'hAA, "arst_d0");
    send_byte(8'hBB, "arst_d1");
    checks++;
    if ({mem_wen_o, busy_o} !== 2'b11) begin
      errors++;
      $display("FAIL arst_pre got wen=%b busy=%b want 1 1", mem_wen_o, busy_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({mem_wen_o, busy_o, done_o, cpu_rst_o, byte_ready_o} !== 5'b00010) begin
      errors++;
      $display("FAIL arst_drop got wen=%b busy=%b done=%b cpu_rst=%b rdy=%b want 0 0 0 1 0",
               mem_wen_o, busy_o, done_o, cpu_rst_o, byte_ready_o);
    end
    exp_q.delete();
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    pulse_start();
    for (int k = 0; k < 4; k++) push_wr(5'(k), 8'(k + 1));
    for (int a = 4; a < 32; a++) push_wr(5'(a), 8'h00);
    send_byte(8'h04, "arst2_len");
    for (int k = 0; k < 4; k++) send_byte(8'(k + 1), "arst2_data");
    send_byte(8'h0A, "arst2_csum");
    repeat (27) tick();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL arst2_early got done=%b want 0", done_o);
    end
    tick();
    checks++;
    if ({done_o, cpu_rst_o, err_o} !== 4'b1000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL arst2_done got done=%b cpu_rst=%b err=%b pending=%0d want 1 0 00 0",
               done_o, cpu_rst_o, err_o, exp_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_bad_len();
    test_bad_csum();
    test_full_gaps();
    test_async_reset();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader for the accumulator CPU. It receives a framed byte stream over a valid/ready handshake and writes the bytes into the 32×8 instruction memory, which is the memory the CPU fetches from. It zero-fills unused locations and holds the CPU in reset until a load completes with a correct checksum.

## Interface
Parameters:
- none; the memory geometry is fixed at 32 words × 8 bits, matching the CPU's 5-bit PC.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begins a load; sampled in IDLE, DONE and ERR only.
- byte_i  in  8  stream byte.
- byte_valid_i  in  1  byte_i is valid.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- mem_wen_o  out  1  instruction-memory write strobe, one word per cycle.
- mem_addr_o  out  5  write address.
- mem_data_o  out  8  write data.
- cpu_rst_o  out  1  CPU reset hold; high while a valid program is not loaded.
- busy_o  out  1  high in LEN, DATA, CSUM and FILL.
- done_o  out  1  load completed successfully.
- err_o  out  2  error code: 00 none, 01 bad length, 10 checksum mismatch.

## Operation
- Frame format: length byte N, then N instruction bytes, then a checksum byte.
  - Legal N is 1..32.
  - Checksum = sum of the N instruction bytes mod 256. The length byte is excluded.
- A byte is accepted on a rising edge where byte_valid_i && byte_ready_o.
- byte_ready_o is high exactly in LEN, DATA and CSUM. Back-to-back acceptance is allowed.
- States and transitions:
  - IDLE: start_i → LEN. Clear the byte counter, running sum and err_o.
  - LEN: on accept, latch N.
    - N==0 or N>32 → ERR with err_o=01.
    - Otherwise → DATA.
  - DATA: on accept of byte k (k = 0..N-1):
    - register mem_wen_o=1, mem_addr_o=k, mem_data_o=byte_i;
    - add the byte to the running sum.
    - After byte N-1 → CSUM.
  - CSUM: on accept, compare the byte with the running sum.
    - Mismatch → ERR with err_o=10. No fill is performed.
    - Match and N==32 → DONE.
    - Match and N<32 → FILL.
  - FILL: one write per cycle with no handshake, addresses N..31, data 0x00. After address 31 has been presented → DONE.
  - DONE: done_o=1 and cpu_rst_o=0. start_i → LEN.
  - ERR: err_o holds its code and cpu_rst_o=1. start_i → LEN.
- Leaving DONE or ERR on start_i:
  - clears done_o and err_o;
  - raises cpu_rst_o at that same edge.
- start_i in LEN, DATA, CSUM or FILL is ignored.
- Counter widths:
  - the byte counter is 6 bits, so it can represent 32;
  - the running sum is 8 bits and wraps.
- Memory words already written before an error are left as written. The CPU stays held in reset.

## Timing
- All outputs are registered except byte_ready_o and busy_o, which decode the state register.
- Reset values (applied asynchronously, independent of the clock):
  - state = IDLE;
  - cpu_rst_o = 1;
  - byte_ready_o, mem_wen_o, busy_o, done_o = 0;
  - mem_addr_o = 0, mem_data_o = 0, err_o = 00.
- Data write latency: the byte accepted at edge t appears as a write in the cycle after t. mem_wen_o drops at the next edge unless another byte is accepted at that edge.
- Fill: if CSUM is accepted at edge t, address N is presented from edge t and address 31 from edge t+31-N.
- Completion: DONE, done_o=1 and cpu_rst_o=0 all take effect at edge t+32-N. For N==32 this is edge t itself.
- Errors: ERR and err_o take effect at the edge that accepts the offending length or checksum byte. mem_wen_o is 0 from that edge.
- Reset mid-operation: rst_i at any point returns immediately to IDLE with the reset values above. Any write in progress is abandoned. cpu_rst_o rises without waiting for a clock.
- Stalls: byte_valid_i may drop for any number of cycles in LEN, DATA or CSUM. State, counter and sum hold, and no spurious writes occur.

## Test plan
- Reset, then release, with no stimulus → all outputs at their reset values; byte_ready_o=0; state stays IDLE for 10 cycles.
- start_i, then stream 0x03, 0x21, 0x42, 0xE0, 0x43 back-to-back:
  - writes (0,0x21), (1,0x42), (2,0xE0);
  - then 29 fill writes to addresses 3..31 with data 0x00;
  - done_o=1 and cpu_rst_o=0 exactly 29 edges after the checksum is accepted.
- Length 0x00 → err_o=01 with no write. Then start_i with length 0x21 → err_o=01, byte_ready_o=0, cpu_rst_o=1.
- Stream 0x02, 0x10, 0x20, 0x31:
  - writes at addresses 0 and 1;
  - err_o=10, no fill writes, done_o=0, cpu_rst_o=1.
- Stream N=32 (bytes 0x00..0x1F, checksum 0xF0) with random valid gaps, and start_i pulsed during DATA:
  - exactly 32 writes in address order;
  - start_i has no effect;
  - done_o rises at the checksum edge.
- Assert rst_i asynchronously between edges during DATA → mem_wen_o, busy_o and done_o drop and cpu_rst_o rises before the next clock edge. A following fresh load completes normally.
